// File: rtl/pcihellocore_push_buttons.sv
// pcihellocore_push_buttons
// Avalon-MM slave input port for board push buttons / switches.
// Raw inputs are synchronized, debounced on a free-running sample tick,
// edge-detected into a write-to-clear capture register, and combined with
// an interrupt mask into a level interrupt for the host.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   address      register word select (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE)
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data
//   readdata     registered read data, one cycle after the chipselect cycle
//   in_port      raw asynchronous inputs
//   irq          level interrupt, high while any unmasked capture bit is set
module pcihellocore_push_buttons #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sample_prev_q, sample_prev_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             tick;
    logic             wr_en;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_mux;

    // Only writedata[WIDTH-1:0] carries register content.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & ~write_n;

    // With DEBOUNCE_CYCLES=1 the counter is a single bit pinned at 0 and
    // CNT_LAST is 0, so tick stays high every cycle.
    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // A bit is accepted only when two consecutive tick samples agree.
    always_comb begin
        sample_prev_d = sample_prev_q;
        stable_d      = stable_q;
        if (tick) begin
            sample_prev_d = sync2_q;
            stable_d      = (stable_q & (sync2_q ^ sample_prev_q))
                          | (sync2_q & ~(sync2_q ^ sample_prev_q));
        end
        stable_dly_d = stable_q;
    end

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = stable_q & ~stable_dly_q;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~stable_q & stable_dly_q;
        end else begin
            edge_det = stable_q ^ stable_dly_q;
        end
    end

    // Clear is applied before the OR so a simultaneous new edge stays set.
    always_comb begin
        cap_clr    = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        edge_cap_d = (edge_cap_q & ~cap_clr) | edge_det;
        irq_mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irq_mask_q;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = stable_q;
            2'd2:    rd_mux[WIDTH-1:0] = irq_mask_q;
            2'd3:    rd_mux[WIDTH-1:0] = edge_cap_q;
            default: rd_mux = '0;
        endcase
        readdata_d = chipselect ? rd_mux : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            cnt_q         <= '0;
            sample_prev_q <= '0;
            stable_q      <= '0;
            stable_dly_q  <= '0;
            edge_cap_q    <= '0;
            irq_mask_q    <= '0;
            readdata_q    <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            cnt_q         <= cnt_d;
            sample_prev_q <= sample_prev_d;
            stable_q      <= stable_d;
            stable_dly_q  <= stable_dly_d;
            edge_cap_q    <= edge_cap_d;
            irq_mask_q    <= irq_mask_d;
            readdata_q    <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pcihellocore_push_buttons.sv
// Testbench for pcihellocore_push_buttons.
// Main instance: WIDTH=4, DEBOUNCE_CYCLES=1, EDGE_TYPE=1 (falling), checked
// every cycle through a scoreboard fed by a history-based reference model.
// Second instance: DEBOUNCE_CYCLES=4, EDGE_TYPE=2 for glitch/latency checks.
module tb_pcihellocore_push_buttons;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port;
    logic          irq;

    logic [1:0]    b_address;
    logic          b_chipselect;
    logic          b_write_n;
    logic [31:0]   b_writedata;
    logic [31:0]   b_readdata;
    logic [W-1:0]  b_in_port;
    logic          b_irq;

    pcihellocore_push_buttons #(.WIDTH(W), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(1)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    pcihellocore_push_buttons #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_dut4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (b_address),
        .chipselect (b_chipselect),
        .write_n    (b_write_n),
        .writedata  (b_writedata),
        .readdata   (b_readdata),
        .in_port    (b_in_port),
        .irq        (b_irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: per-edge input sample history plus register images.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_stable, m_stable_old, m_cap, m_mask;
    logic [31:0]  m_rd;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: one expected entry per clock edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check32("sb_readdata", readdata, e.rd);
            check32("sb_irq", {31'd0, irq}, {31'd0, e.irq});
        end
    end

    task automatic model_reset();
        hist.delete();
        // Synchronizer and sample stages all reset to 0: treat as three zero samples.
        repeat (3) hist.push_back('0);
        m_stable     = '0;
        m_stable_old = '0;
        m_cap        = '0;
        m_mask       = '0;
        m_rd         = '0;
        sb_q.delete();
    endtask

    // Advance one clock with the currently driven inputs; returns at the negedge.
    task automatic cyc();
        logic         wr;
        logic [W-1:0] clr, fall, a, b, cap_n, mask_n, st_n;
        exp_t         e;
        wr = chipselect && !write_n;
        if (chipselect) begin
            case (address)
                2'd0:    m_rd = 32'(m_stable);
                2'd2:    m_rd = 32'(m_mask);
                2'd3:    m_rd = 32'(m_cap);
                default: m_rd = 32'd0;
            endcase
        end
        fall   = m_stable_old & ~m_stable;
        clr    = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        cap_n  = (m_cap & ~clr) | fall;
        mask_n = (wr && address == 2'd2) ? writedata[W-1:0] : m_mask;
        hist.push_back(in_port);
        if (hist.size() > 4) void'(hist.pop_front());
        // hist[1] = sample two edges ago, hist[0] = three edges ago
        a = hist[1];
        b = hist[0];
        st_n = m_stable;
        for (int i = 0; i < W; i++) begin
            if (a[i] == b[i]) st_n[i] = a[i];
        end
        m_stable_old = m_stable;
        m_stable     = st_n;
        m_cap        = cap_n;
        m_mask       = mask_n;
        e.rd  = m_rd;
        e.irq = |(cap_n & mask_n);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (n) cyc();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        cyc();
        chipselect = 1'b0;
        check32(name, readdata, exp);
    endtask

    task automatic do_reset(input logic [W-1:0] hold_val);
        reset_n    = 1'b0;
        in_port    = hold_val;
        chipselect = 1'b0;
        write_n    = 1'b1;
        #1;
        check32("reset_irq_async", {31'd0, irq}, 32'd0);
        check32("reset_readdata_async", readdata, 32'd0);
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check32("irq_during_reset", {31'd0, irq}, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic b_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        b_chipselect = 1'b1;
        b_address    = a;
        @(posedge clk);
        @(negedge clk);
        b_chipselect = 1'b0;
        check32(name, b_readdata, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        address      = 2'd0;
        writedata    = 32'd0;
        b_address    = 2'd0;
        b_chipselect = 1'b0;
        b_write_n    = 1'b1;
        b_writedata  = 32'd0;
        b_in_port    = '0;

        // Reset with inputs held high; they appear as a rising edge afterwards.
        do_reset(4'hF);
        idle(5);
        bus_rd(2'd0, 32'h0000000F, "data_after_reset");
        bus_rd(2'd3, 32'h00000000, "cap_after_reset");

        // Falling edge on bit 0, masked in: capture and irq at E4.
        bus_wr(2'd2, 32'h1);
        in_port = 4'hE;
        repeat (4) cyc();
        check32("irq_before_e4", {31'd0, irq}, 32'd0);
        cyc();
        check32("irq_at_e4", {31'd0, irq}, 32'd1);
        bus_rd(2'd3, 32'h1, "cap_fall_bit0");
        bus_wr(2'd3, 32'h1);
        check32("irq_after_clear", {31'd0, irq}, 32'd0);
        bus_rd(2'd3, 32'h0, "cap_cleared");

        // Masking: capture bit 2 with mask off, then unmask and remask.
        bus_wr(2'd2, 32'h0);
        in_port = 4'hA;
        idle(6);
        check32("irq_masked", {31'd0, irq}, 32'd0);
        bus_rd(2'd3, 32'h4, "cap_bit2_masked");
        bus_wr(2'd2, 32'h4);
        check32("irq_unmasked", {31'd0, irq}, 32'd1);
        bus_wr(2'd2, 32'h0);
        check32("irq_remasked", {31'd0, irq}, 32'd0);
        bus_wr(2'd3, 32'hF);

        // Single-cycle glitch on bit 0 is rejected.
        in_port = 4'hB;
        idle(6);
        bus_rd(2'd3, 32'h0, "cap_after_rise");
        in_port = 4'hA;
        cyc();
        in_port = 4'hB;
        idle(6);
        bus_rd(2'd0, 32'hB, "data_glitch_rejected");
        bus_rd(2'd3, 32'h0, "cap_glitch_rejected");

        // Clear of bit 1 in the same cycle as its new falling edge: set wins.
        bus_wr(2'd2, 32'h2);
        in_port = 4'h9;
        repeat (4) cyc();
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd3;
        writedata  = 32'h2;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        check32("irq_set_wins", {31'd0, irq}, 32'd1);
        bus_rd(2'd3, 32'h2, "cap_set_wins");

        // Bus corners.
        bus_wr(2'd0, 32'hFFFFFFFF);
        bus_wr(2'd1, 32'hFFFFFFFF);
        bus_rd(2'd0, 32'h9, "data_write_ignored");
        bus_rd(2'd1, 32'h0, "addr1_reads_zero");
        bus_wr(2'd2, 32'hFFFFFFFF);
        bus_rd(2'd2, 32'h0000000F, "mask_upper_zero");
        address = 2'd0;
        idle(3);
        check32("readdata_hold", readdata, 32'h0000000F);
        check32("irq_before_midreset", {31'd0, irq}, 32'd1);

        // Reset mid-operation with irq high.
        @(negedge clk);
        do_reset(4'hF);
        idle(5);
        bus_rd(2'd0, 32'hF, "data_after_midreset");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
            chipselect = 1'b0;
            write_n    = 1'b1;
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            case ($urandom_range(0, 5))
                2: chipselect = 1'b1;
                3: begin chipselect = 1'b1; write_n = 1'b0; address = 2'd2; end
                4: begin chipselect = 1'b1; write_n = 1'b0; address = 2'd3; end
                5: begin chipselect = 1'b1; write_n = 1'b0; end
                default: chipselect = 1'b0;
            endcase
            cyc();
        end
        idle(2);

        // DEBOUNCE_CYCLES=4 instance: a 3-cycle pulse is rejected.
        repeat (10) @(negedge clk);
        b_in_port = 4'h1;
        repeat (3) @(negedge clk);
        b_in_port = 4'h0;
        repeat (12) @(negedge clk);
        b_read(2'd0, 32'h0, "n4_pulse_data");
        b_read(2'd3, 32'h0, "n4_pulse_cap");
        // A held level is accepted within 10 cycles.
        b_in_port = 4'h1;
        repeat (10) @(negedge clk);
        b_read(2'd0, 32'h1, "n4_held_data");
        b_read(2'd3, 32'h1, "n4_held_cap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
